// File: rtl/id_operand_stage.sv
// ID operand stage: resolves RAW hazards against EX/MEM by forwarding or interlock and registers
// operands into the ID/EX register. Define ID_FWD_EN to enable the EX/MEM forwarding paths.
module id_operand_stage #(
    parameter int          XLEN          = 32,
    parameter int          PC_W          = 32,
    parameter logic [31:0] STALL_CNT_MAX = 32'hFFFF_FFFF
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [PC_W-1:0] in_pc,
    input  logic [4:0]      in_rj,
    input  logic [4:0]      in_rk,
    input  logic            in_rj_use,
    input  logic            in_rk_use,
    input  logic [4:0]      in_rd,
    input  logic            in_rd_we,
    input  logic            in_is_load,
    input  logic [XLEN-1:0] in_imm,
    input  logic [XLEN-1:0] rf_rdata1,
    input  logic [XLEN-1:0] rf_rdata2,
    input  logic [4:0]      ex_rd,
    input  logic            ex_we,
    input  logic            ex_is_load,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_result,
    input  logic [4:0]      mem_rd,
    input  logic            mem_we,
    input  logic            mem_valid,
    input  logic [XLEN-1:0] mem_result,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [PC_W-1:0] out_pc,
    output logic [XLEN-1:0] out_src1,
    output logic [XLEN-1:0] out_src2,
    output logic [XLEN-1:0] out_imm,
    output logic [4:0]      out_rd,
    output logic            out_rd_we,
    output logic            out_is_load,
    output logic [31:0]     stall_cnt
);

    logic            ex_hit_j, ex_hit_k, mem_hit_j, mem_hit_k;
    logic            hazard, accept;
    logic [XLEN-1:0] src1_d, src2_d;

    logic            out_valid_q;
    logic [PC_W-1:0] out_pc_q;
    logic [XLEN-1:0] out_src1_q, out_src2_q, out_imm_q;
    logic [4:0]      out_rd_q;
    logic            out_rd_we_q, out_is_load_q;
    logic [31:0]     stall_cnt_q;

    // Register 0 is excluded so a write to r0 in flight never creates a dependency.
    assign ex_hit_j  = ex_valid  && ex_we  && (ex_rd  == in_rj) && (in_rj != 5'd0) && in_rj_use;
    assign ex_hit_k  = ex_valid  && ex_we  && (ex_rd  == in_rk) && (in_rk != 5'd0) && in_rk_use;
    assign mem_hit_j = mem_valid && mem_we && (mem_rd == in_rj) && (in_rj != 5'd0) && in_rj_use;
    assign mem_hit_k = mem_valid && mem_we && (mem_rd == in_rk) && (in_rk != 5'd0) && in_rk_use;

`ifdef ID_FWD_EN
    assign hazard = ex_is_load && (ex_hit_j || ex_hit_k);
`else
    // Without bypass paths the stage waits until every producer has reached WB.
    assign hazard = ex_hit_j || ex_hit_k || mem_hit_j || mem_hit_k;

    logic unused_fwd;
    assign unused_fwd = ^{ex_result, mem_result, ex_is_load};
`endif

    always_comb begin
        // NOTE: defaults first so every path assigns src*_d and no latch is inferred.
        src1_d = rf_rdata1;
        src2_d = rf_rdata2;
`ifdef ID_FWD_EN
        if (ex_hit_j)       src1_d = ex_result;
        else if (mem_hit_j) src1_d = mem_result;
        if (ex_hit_k)       src2_d = ex_result;
        else if (mem_hit_k) src2_d = mem_result;
`endif
        if (in_rj == 5'd0)  src1_d = '0;
        if (in_rk == 5'd0)  src2_d = '0;
    end

    assign in_ready = rst && !hazard && (!out_valid_q || out_ready) && !flush;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid_q   <= 1'b0;
            out_pc_q      <= '0;
            out_src1_q    <= '0;
            out_src2_q    <= '0;
            out_imm_q     <= '0;
            out_rd_q      <= '0;
            out_rd_we_q   <= 1'b0;
            out_is_load_q <= 1'b0;
            stall_cnt_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            if (flush)          out_valid_q <= 1'b0;
            else if (accept)    out_valid_q <= 1'b1;
            else if (out_ready) out_valid_q <= 1'b0;

            if (accept) begin
                out_pc_q      <= in_pc;
                out_src1_q    <= src1_d;
                out_src2_q    <= src2_d;
                out_imm_q     <= in_imm;
                out_rd_q      <= in_rd;
                out_rd_we_q   <= in_rd_we;
                out_is_load_q <= in_is_load;
            end

            if (in_valid && !in_ready && !flush && (stall_cnt_q != STALL_CNT_MAX))
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_pc      = out_pc_q;
    assign out_src1    = out_src1_q;
    assign out_src2    = out_src2_q;
    assign out_imm     = out_imm_q;
    assign out_rd      = out_rd_q;
    assign out_rd_we   = out_rd_we_q;
    assign out_is_load = out_is_load_q;
    assign stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_id_operand_stage.sv
// Self-checking bench for id_operand_stage: directed vector table, reset/saturation sequences,
// and randomized traffic against a behavioural model. Follows ID_FWD_EN like the design.
module tb_id_operand_stage;

    localparam int          XLEN    = 32;
    localparam int          PC_W    = 32;
    localparam logic [31:0] SAT_MAX = 32'd40;

    logic            clk = 1'b0;
    logic            rst, flush, in_valid, in_rj_use, in_rk_use, in_rd_we, in_is_load;
    logic [PC_W-1:0] in_pc;
    logic [4:0]      in_rj, in_rk, in_rd, ex_rd, mem_rd;
    logic [XLEN-1:0] in_imm, rf_rdata1, rf_rdata2, ex_result, mem_result;
    logic            ex_we, ex_is_load, ex_valid, mem_we, mem_valid, out_ready;

    logic            in_ready, out_valid, out_rd_we, out_is_load;
    logic [PC_W-1:0] out_pc;
    logic [XLEN-1:0] out_src1, out_src2, out_imm;
    logic [4:0]      out_rd;
    logic [31:0]     stall_cnt;

    logic            s_in_ready, s_out_valid, unused_s_we, unused_s_ld;
    logic [PC_W-1:0] unused_s_pc;
    logic [XLEN-1:0] s_out_src1, unused_s_src2, unused_s_imm;
    logic [4:0]      unused_s_rd;
    logic [31:0]     s_stall_cnt;

    int tests = 0;
    int fails = 0;

    // Expected ID/EX register contents and counters.
    logic            m_valid, m_rd_we, m_ld;
    logic [PC_W-1:0] m_pc;
    logic [XLEN-1:0] m_src1, m_src2, m_imm;
    logic [4:0]      m_rd;
    logic [31:0]     m_cnt, m_cnt_sat;

    id_operand_stage #(.XLEN(XLEN), .PC_W(PC_W)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rj(in_rj), .in_rk(in_rk), .in_rj_use(in_rj_use), .in_rk_use(in_rk_use),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_imm(in_imm),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_valid(mem_valid), .mem_result(mem_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_src1(out_src1),
        .out_src2(out_src2), .out_imm(out_imm), .out_rd(out_rd), .out_rd_we(out_rd_we),
        .out_is_load(out_is_load), .stall_cnt(stall_cnt)
    );

    // Second instance with a low ceiling so counter saturation is reachable in a short run.
    id_operand_stage #(.XLEN(XLEN), .PC_W(PC_W), .STALL_CNT_MAX(SAT_MAX)) dut_sat (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_pc(in_pc), .in_rj(in_rj), .in_rk(in_rk), .in_rj_use(in_rj_use), .in_rk_use(in_rk_use),
        .in_rd(in_rd), .in_rd_we(in_rd_we), .in_is_load(in_is_load), .in_imm(in_imm),
        .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .ex_rd(ex_rd), .ex_we(ex_we), .ex_is_load(ex_is_load), .ex_valid(ex_valid), .ex_result(ex_result),
        .mem_rd(mem_rd), .mem_we(mem_we), .mem_valid(mem_valid), .mem_result(mem_result),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_pc(unused_s_pc), .out_src1(s_out_src1),
        .out_src2(unused_s_src2), .out_imm(unused_s_imm), .out_rd(unused_s_rd), .out_rd_we(unused_s_we),
        .out_is_load(unused_s_ld), .stall_cnt(s_stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    function automatic logic hit(input logic pv, input logic pwe, input logic [4:0] prd,
                                 input logic [4:0] s, input logic u);
        return pv && pwe && u && (s != 5'd0) && (prd == s);
    endfunction

    function automatic logic [XLEN-1:0] operand(input logic [4:0] s, input logic u,
                                                input logic [XLEN-1:0] rf);
        if (s == 5'd0) return '0;
`ifdef ID_FWD_EN
        if (hit(ex_valid, ex_we, ex_rd, s, u))     return ex_result;
        if (hit(mem_valid, mem_we, mem_rd, s, u))  return mem_result;
`endif
        return rf;
    endfunction

    function automatic logic model_ready();
        logic ej, ek, mj, mk, hz;
        ej = hit(ex_valid, ex_we, ex_rd, in_rj, in_rj_use);
        ek = hit(ex_valid, ex_we, ex_rd, in_rk, in_rk_use);
        mj = hit(mem_valid, mem_we, mem_rd, in_rj, in_rj_use);
        mk = hit(mem_valid, mem_we, mem_rd, in_rk, in_rk_use);
`ifdef ID_FWD_EN
        hz = ex_is_load && (ej || ek);
`else
        hz = ej || ek || mj || mk;
`endif
        return rst && !hz && (!m_valid || out_ready) && !flush;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
        longint nxt;
        nxt = longint'(v) + 1;
        return (nxt > longint'(max)) ? max : 32'(nxt);
    endfunction

    task automatic model_reset();
        m_valid = 0; m_pc = '0; m_src1 = '0; m_src2 = '0; m_imm = '0;
        m_rd = '0; m_rd_we = 0; m_ld = 0; m_cnt = '0; m_cnt_sat = '0;
    endtask

    task automatic model_update(input logic rdy);
        if (in_valid && !rdy && !flush) begin
            m_cnt     = sat_inc(m_cnt, 32'hFFFF_FFFF);
            m_cnt_sat = sat_inc(m_cnt_sat, SAT_MAX);
        end
        if (flush) m_valid = 0;
        else if (in_valid && rdy) begin
            m_valid = 1;
            m_pc    = in_pc;
            m_src1  = operand(in_rj, in_rj_use, rf_rdata1);
            m_src2  = operand(in_rk, in_rk_use, rf_rdata2);
            m_imm   = in_imm;
            m_rd    = in_rd;
            m_rd_we = in_rd_we;
            m_ld    = in_is_load;
        end else if (out_ready) m_valid = 0;
    endtask

    // One clock: inputs are already driven; check in_ready, clock, check the register.
    task automatic step(output logic rdy_seen);
        logic exp_rdy;
        #1;
        exp_rdy  = model_ready();
        rdy_seen = in_ready;
        check("in_ready", in_ready, exp_rdy);
        check("sat_in_ready", s_in_ready, exp_rdy);
        @(posedge clk);
        model_update(exp_rdy);
        #1;
        check("out_valid", out_valid, m_valid);
        check("out_pc", out_pc, m_pc);
        check("out_src1", out_src1, m_src1);
        check("out_src2", out_src2, m_src2);
        check("out_imm", out_imm, m_imm);
        check("out_rd", out_rd, m_rd);
        check("out_rd_we", out_rd_we, m_rd_we);
        check("out_is_load", out_is_load, m_ld);
        check("stall_cnt", stall_cnt, m_cnt);
        check("sat_out_valid", s_out_valid, m_valid);
        check("sat_out_src1", s_out_src1, m_src1);
        check("sat_stall_cnt", s_stall_cnt, m_cnt_sat);
    endtask

    task automatic idle_inputs();
        flush = 0; in_valid = 0; in_pc = '0; in_rj = '0; in_rk = '0; in_rj_use = 1; in_rk_use = 1;
        in_rd = '0; in_rd_we = 0; in_is_load = 0; in_imm = '0; rf_rdata1 = '0; rf_rdata2 = '0;
        ex_rd = '0; ex_we = 1; ex_is_load = 0; ex_valid = 0; ex_result = '0;
        mem_rd = '0; mem_we = 1; mem_valid = 0; mem_result = '0; out_ready = 1;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic            iv;
        logic [4:0]      rj, rk;
        logic [XLEN-1:0] rf1, rf2;
        logic            exv, exld;
        logic [4:0]      exrd;
        logic [XLEN-1:0] exres;
        logic            memv;
        logic [4:0]      memrd;
        logic [XLEN-1:0] memres;
        logic            ordy, fl;
        logic            e_rdy, e_ov;
        logic [XLEN-1:0] e_s1, e_s2;
        logic [31:0]     e_cnt;
    } vec_t;

    function automatic vec_t mk(input logic iv, input logic [4:0] rj, input logic [4:0] rk,
                                input logic [31:0] rf1, input logic [31:0] rf2,
                                input logic exv, input logic exld, input logic [4:0] exrd,
                                input logic [31:0] exres, input logic memv, input logic [4:0] memrd,
                                input logic [31:0] memres, input logic ordy, input logic fl,
                                input logic e_rdy, input logic e_ov, input logic [31:0] e_s1,
                                input logic [31:0] e_s2, input logic [31:0] e_cnt);
        vec_t v;
        v.iv = iv; v.rj = rj; v.rk = rk; v.rf1 = rf1; v.rf2 = rf2;
        v.exv = exv; v.exld = exld; v.exrd = exrd; v.exres = exres;
        v.memv = memv; v.memrd = memrd; v.memres = memres; v.ordy = ordy; v.fl = fl;
        v.e_rdy = e_rdy; v.e_ov = e_ov; v.e_s1 = e_s1; v.e_s2 = e_s2; v.e_cnt = e_cnt;
        return v;
    endfunction

    vec_t tbl[$];
    logic rdy_seen;

    initial begin
`ifdef ID_FWD_EN
        tbl.push_back(mk(1, 5, 0, 32'hDEAD, 0,     1, 0, 5, 32'h1234, 0, 0, 0,       1, 0, 1, 1, 32'h1234, 0, 0));
        tbl.push_back(mk(1, 0, 3, 32'h55, 32'h99,  1, 0, 3, 32'h1,    1, 3, 32'h2,   1, 0, 1, 1, 0, 32'h1, 0));
        tbl.push_back(mk(1, 0, 0, 32'h77, 32'h88,  1, 0, 0, 32'hAA,   0, 0, 0,       1, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk(1, 7, 0, 32'h1111, 0,     1, 1, 7, 32'hBAD,  0, 0, 0,       1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 7, 0, 32'h1111, 0,     0, 0, 0, 0,        1, 7, 32'hCAFE, 1, 0, 1, 1, 32'hCAFE, 0, 1));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 0, 32'h10, 0,   0, 0, 0, 0,        0, 0, 0,       0, 0, 0, 1, 32'hCAFE, 0, 32'(2 + i)));
        tbl.push_back(mk(1, 1, 0, 32'h10, 0,       0, 0, 0, 0,        0, 0, 0,       0, 1, 0, 0, 32'hCAFE, 0, 4));
        tbl.push_back(mk(1, 1, 0, 32'h10, 0,       0, 0, 0, 0,        0, 0, 0,       1, 0, 1, 1, 32'h10, 0, 4));
`else
        tbl.push_back(mk(1, 5, 0, 32'hDEAD, 0,     1, 0, 5, 32'h1234, 0, 0, 0,       1, 0, 0, 0, 0, 0, 1));
        tbl.push_back(mk(1, 5, 0, 32'hDEAD, 0,     0, 0, 0, 0,        1, 5, 32'h1234, 1, 0, 0, 0, 0, 0, 2));
        tbl.push_back(mk(1, 5, 0, 32'hDEAD, 0,     0, 0, 0, 0,        0, 0, 0,       1, 0, 1, 1, 32'hDEAD, 0, 2));
        tbl.push_back(mk(1, 0, 3, 32'h55, 32'h99,  1, 0, 3, 32'h1,    1, 3, 32'h2,   1, 0, 0, 0, 32'hDEAD, 0, 3));
        tbl.push_back(mk(1, 0, 3, 32'h55, 32'h99,  0, 0, 0, 0,        0, 0, 0,       1, 0, 1, 1, 0, 32'h99, 3));
        tbl.push_back(mk(1, 0, 0, 32'h77, 32'h88,  1, 0, 0, 32'hAA,   0, 0, 0,       1, 0, 1, 1, 0, 0, 3));
        tbl.push_back(mk(1, 7, 0, 32'h1111, 0,     1, 1, 7, 32'hBAD,  0, 0, 0,       1, 0, 0, 0, 0, 0, 4));
        tbl.push_back(mk(1, 7, 0, 32'h1111, 0,     0, 0, 0, 0,        1, 7, 32'hCAFE, 1, 0, 0, 0, 0, 0, 5));
        tbl.push_back(mk(1, 7, 0, 32'hCAFE, 0,     0, 0, 0, 0,        0, 0, 0,       1, 0, 1, 1, 32'hCAFE, 0, 5));
        for (int i = 0; i < 3; i++)
            tbl.push_back(mk(1, 1, 0, 32'h10, 0,   0, 0, 0, 0,        0, 0, 0,       0, 0, 0, 1, 32'hCAFE, 0, 32'(6 + i)));
        tbl.push_back(mk(1, 1, 0, 32'h10, 0,       0, 0, 0, 0,        0, 0, 0,       0, 1, 0, 0, 32'hCAFE, 0, 8));
        tbl.push_back(mk(1, 1, 0, 32'h10, 0,       0, 0, 0, 0,        0, 0, 0,       1, 0, 1, 1, 32'h10, 0, 8));
`endif

        // Power-on reset: outputs must be zero while rst is low.
        idle_inputs();
        rst = 0;
        model_reset();
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_stall_cnt", stall_cnt, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;

        foreach (tbl[i]) begin
            in_valid = tbl[i].iv; in_rj = tbl[i].rj; in_rk = tbl[i].rk;
            rf_rdata1 = tbl[i].rf1; rf_rdata2 = tbl[i].rf2;
            ex_valid = tbl[i].exv; ex_is_load = tbl[i].exld; ex_rd = tbl[i].exrd; ex_result = tbl[i].exres;
            mem_valid = tbl[i].memv; mem_rd = tbl[i].memrd; mem_result = tbl[i].memres;
            out_ready = tbl[i].ordy; flush = tbl[i].fl;
            in_pc = 32'h1000 + 32'(i) * 4; in_imm = ~32'(i); in_rd = 5'(i); in_rd_we = 1;
            step(rdy_seen);
            check($sformatf("tbl%0d_rdy", i), rdy_seen, tbl[i].e_rdy);
            check($sformatf("tbl%0d_ov", i), out_valid, tbl[i].e_ov);
            check($sformatf("tbl%0d_src1", i), out_src1, tbl[i].e_s1);
            check($sformatf("tbl%0d_src2", i), out_src2, tbl[i].e_s2);
            check($sformatf("tbl%0d_cnt", i), stall_cnt, tbl[i].e_cnt);
        end

        // Reset asserted mid-cycle while the register holds an instruction.
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        rst = 0;
        model_reset();
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_src1", out_src1, 0);
        check("mid_rst_out_pc", out_pc, 0);
        check("mid_rst_out_rd", out_rd, 0);
        check("mid_rst_stall_cnt", stall_cnt, 0);
        check("mid_rst_in_ready", in_ready, 0);
        @(negedge clk);
        idle_inputs();
        rst = 1;
        @(posedge clk);
        #1;
        check("post_rst_out_valid", out_valid, 0);
        check("post_rst_stall_cnt", stall_cnt, 0);

        // Sustained back-pressure stall drives the low-ceiling counter into saturation.
        in_valid = 1; in_rj = 2; rf_rdata1 = 32'h42; in_pc = 32'h2000;
        step(rdy_seen);
        out_ready = 0;
        repeat (int'(SAT_MAX) + 3) step(rdy_seen);
        check("sat_reached", s_stall_cnt, SAT_MAX);
        repeat (2) step(rdy_seen);
        check("sat_held", s_stall_cnt, SAT_MAX);
        check("nosat_count", stall_cnt, SAT_MAX + 5);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            in_valid   = ($urandom_range(0, 3) != 0);
            out_ready  = ($urandom_range(0, 3) != 0);
            flush      = ($urandom_range(0, 15) == 0);
            in_pc      = $urandom;
            in_imm     = $urandom;
            in_rj      = 5'($urandom_range(0, 7));
            in_rk      = 5'($urandom_range(0, 7));
            in_rj_use  = ($urandom_range(0, 4) != 0);
            in_rk_use  = ($urandom_range(0, 4) != 0);
            in_rd      = 5'($urandom_range(0, 31));
            in_rd_we   = 1'($urandom_range(0, 1));
            in_is_load = 1'($urandom_range(0, 1));
            rf_rdata1  = $urandom;
            rf_rdata2  = $urandom;
            ex_valid   = 1'($urandom_range(0, 1));
            ex_we      = ($urandom_range(0, 3) != 0);
            ex_is_load = ($urandom_range(0, 2) == 0);
            ex_rd      = 5'($urandom_range(0, 7));
            ex_result  = $urandom;
            mem_valid  = 1'($urandom_range(0, 1));
            mem_we     = ($urandom_range(0, 3) != 0);
            mem_rd     = 5'($urandom_range(0, 7));
            mem_result = $urandom;
            step(rdy_seen);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_operand_stage.md
# id_operand_stage

Decode-side operand stage of the 5-stage LoongArch pipeline. It sits directly downstream of the register file.
- It takes the register file's read data for the instruction in ID and resolves RAW hazards against EX and MEM by forwarding or interlock.
- It inserts load-use bubbles and registers the resolved operands into the ID/EX pipeline register.
- It uses a valid/ready handshake on both sides, and exposes a flush input for redirects.

## Interface
Parameters:
- `XLEN`, 32, datapath width
- `PC_W`, 32, program counter width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `flush`  in  1  redirect; kills the ID instruction and the output register
- `in_valid`  in  1  IF/ID holds an instruction
- `in_ready`  out  1  this stage accepts the instruction this cycle
- `in_pc`  in  PC_W  instruction PC
- `in_rj`, `in_rk`  in  5  source register numbers (also drive the RF read addresses)
- `in_rj_use`, `in_rk_use`  in  1  source is actually read
- `in_rd`  in  5  destination register number
- `in_rd_we`  in  1  instruction writes `in_rd`
- `in_is_load`  in  1  instruction is a load
- `in_imm`  in  XLEN  decoded immediate
- `rf_rdata1`, `rf_rdata2`  in  XLEN  register file data for `in_rj`/`in_rk`; valid in the same cycle
- `ex_rd`, `ex_we`, `ex_is_load`, `ex_valid`, `ex_result`  in  5/1/1/1/XLEN  EX-stage producer
- `mem_rd`, `mem_we`, `mem_valid`, `mem_result`  in  5/1/1/XLEN  MEM-stage producer; result is final
- `out_valid`  out  1  ID/EX register holds an instruction
- `out_ready`  in  1  EX consumes the register this cycle
- `out_pc`, `out_src1`, `out_src2`, `out_imm`, `out_rd`, `out_rd_we`, `out_is_load`  out  PC_W/XLEN/XLEN/XLEN/5/1/1  registered operands
- `stall_cnt`  out  32  saturating count of cycles with `in_valid` && !`in_ready`

## Operation
- **Match rule.** A producer P matches source S when all of the following hold:
  - `P_valid` and `P_we` are set.
  - `P_rd` == S and S != 0.
  - The corresponding `*_use` is set.
  - Register 0 never matches and always reads as 0.
- **Forward priority.** EX match first, then MEM match, then `rf_rdata*`. A WB-stage write needs no forwarding: the RF writes at posedge and reads at negedge.
- **Load-use hazard.** An EX match with `ex_is_load`=1 is a load-use hazard. The result is `hazard`=1: the input is not accepted and a bubble is offered to EX.
- **Input acceptance.**
  - `in_ready` = !`hazard` && (!`out_valid` || `out_ready`) && !`flush`.
  - When `in_valid` && `in_ready`, the output register loads the resolved operands and `out_valid` becomes 1.
  - When `out_ready` && !(`in_valid` && `in_ready`), `out_valid` becomes 0 (bubble).
- **Flush.** `out_valid` becomes 0 next edge, regardless of other inputs. `flush` has priority over load.
- **Stall counter.** `stall_cnt` increments on each cycle with `in_valid` && !`in_ready` && !`flush`. It saturates at 0xFFFF_FFFF.
- **Reset.** On `rst` low, all outputs reset immediately to 0: `out_valid`, all `out_*` data fields and `stall_cnt`. `in_ready` is combinational and is 0 while `rst` is low.

## Timing
- Latency is 1 cycle: data accepted at edge N is visible on `out_*` after edge N.
- `in_ready` is combinational from `flush`, `ex_*`, `mem_*`, `out_valid`, `out_ready` and `in_*`. There is no combinational path from `in_valid` to `in_ready`.
- A load-use hazard costs exactly 1 bubble cycle when the load advances to MEM on the next edge. The stall extends while EX holds the load.
- A producer that matches both EX and MEM selects EX, the younger producer.
- Reset asserted mid-transfer discards the output register contents. No transfer completes in the cycle `rst` deasserts with `in_valid` low.
- Back-pressure: with `out_ready`=0 and `out_valid`=1, the output register holds all fields stable.

## Configuration
- `ID_FWD_EN` defined:
  - Forwarding as above.
  - Only the load-use case stalls.
- `ID_FWD_EN` undefined:
  - There is no forwarding path; operands always come from `rf_rdata*`.
  - `hazard` asserts on any EX or MEM match, load or not.
  - The stage interlocks until producers reach WB.
  - `ex_result` and `mem_result` are unused.

## Test plan
- **Reset.** Assert `rst`=0 with `out_valid`=1 mid-cycle → all outputs 0 immediately. After release, `stall_cnt`=0.
- **EX forward.** EX add writes r5=0x1234 with `ex_is_load`=0; ID reads `in_rj`=5 with `rf_rdata1`=0xDEAD → `out_src1`=0x1234 after 1 cycle and no stall. With `ID_FWD_EN` off: 2 stall cycles, then `out_src1` from RF.
- **Priority.** EX r3=0x1 and MEM r3=0x2 both match → `out_src2`=0x1. Register 0: `ex_rd`=0 with `in_rj`=0 → `out_src1`=0.
- **Load-use.** EX load r7, ID reads r7 → `in_ready`=0 for 1 cycle, one bubble (`out_valid`=0), `stall_cnt`=1. Next cycle forwards `mem_result`=0xCAFE.
- **Back-pressure and flush.** With `out_ready`=0 for 3 cycles, `out_*` is held. Then `flush`=1 with `in_valid`=1 → `out_valid`=0 next edge and the input is not accepted.
- **Saturation.** Preload `stall_cnt` near its maximum via a sustained stall, then hold the stall for 2 more cycles → `stall_cnt` stays 0xFFFF_FFFF.
